// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the serial receive path.
// Imported by the frame assembler and its output queue.
package serial_rx_pkg;

    localparam int DATA_BITS      = 8;
    localparam int DEF_FRAME_BITS = 10;

    typedef struct packed {
        logic                 err;
        logic [DATA_BITS-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/rx_fifo.sv
// Circular-buffer FIFO with extra-wide pointers so full and empty stay distinct on wrap.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module rx_fifo
    import serial_rx_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = rx_entry_t,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  entry_t       push_data,
    input  logic         pop,
    output entry_t       pop_data,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count
);

    entry_t        mem [DEPTH];
    logic   [AW:0] wr_ptr;
    logic   [AW:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: storage has no reset; empty gating at the consumer hides stale contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/serial_in_buffer.sv
// Receive data stage: synchronizes the serial line, assembles frames on controller strobes,
// checks framing on end-of-character and queues {err, data} for a valid/ready consumer.
module serial_in_buffer
    import serial_rx_pkg::*;
#(
    parameter int  FRAME_BITS = DEF_FRAME_BITS,
    parameter int  FIFO_DEPTH = 4,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ser_data_in,
    input  logic                 sr_clk,
    input  logic                 char_received,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_err,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [CNT_W-1:0]     rx_count,
    output logic                 overflow,
    input  logic                 overflow_clr
);

    localparam int               BIT_W     = $clog2(FRAME_BITS + 1);
    localparam logic [BIT_W-1:0] FRAME_CNT = BIT_W'(FRAME_BITS);

    logic                  ser_meta;
    logic                  ser_s;
    logic                  sr_clk_q;
    logic                  cr_q;
    logic                  sr_rise;
    logic                  cr_rise;

    logic [FRAME_BITS-1:0] shift_reg;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  long_frame;
    logic [FRAME_BITS-1:0] shift_nxt;
    logic [BIT_W-1:0]      cnt_nxt;
    logic                  long_nxt;

    rx_entry_t             push_entry;
    rx_entry_t             head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            ser_meta <= 1'b1;
            ser_s    <= 1'b1;
            sr_clk_q <= 1'b0;
            cr_q     <= 1'b0;
        end else begin
            ser_meta <= ser_data_in;
            ser_s    <= ser_meta;
            sr_clk_q <= sr_clk;
            cr_q     <= char_received;
        end
    end

    assign sr_rise = sr_clk && !sr_clk_q;
    assign cr_rise = char_received && !cr_q;

    // Frame state after this cycle's sample, so a coincident close sees the final sample.
    // NOTE: every always_comb output gets a default first, which rules out inferred latches.
    always_comb begin
        shift_nxt = shift_reg;
        cnt_nxt   = bit_cnt;
        long_nxt  = long_frame;
        if (sr_rise) begin
            if (bit_cnt < FRAME_CNT) begin
                for (int i = 0; i < FRAME_BITS; i++) begin
                    if (BIT_W'(i) == bit_cnt) shift_nxt[i] = ser_s;
                end
                cnt_nxt = bit_cnt + BIT_W'(1);
            end else begin
                long_nxt = 1'b1;
            end
        end
    end

    always_comb begin
        push_entry.data = shift_nxt[DATA_BITS:1];
        push_entry.err  = (cnt_nxt != FRAME_CNT) || long_nxt
                        || shift_nxt[0] || !shift_nxt[FRAME_BITS-1];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || cr_rise) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            long_frame <= 1'b0;
        end else begin
            shift_reg  <= shift_nxt;
            bit_cnt    <= cnt_nxt;
            long_frame <= long_nxt;
        end
    end

    assign pop = rx_ready && !fifo_empty;

    // A drop wins over a same-cycle clear so the loss is never hidden.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (cr_rise && fifo_full && !pop) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

    rx_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (rx_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cr_rise),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (rx_count)
    );

    assign rx_valid = !fifo_empty;
    assign rx_data  = fifo_empty ? '0   : head.data;
    assign rx_err   = fifo_empty ? 1'b0 : head.err;

endmodule

// File: doc/serial_in_buffer.md
# serial_in_buffer

Receive-side data stage directly downstream of the serial receive controller. Samples the serial line on each shift-clock strobe from the controller, assembles a start/8-data/stop frame, checks framing when the controller flags end of character, and queues the byte with an error flag in a small FIFO. The CPU/display logic drains the FIFO through a valid/ready handshake.

## Interface
- FRAME_BITS, 10, samples per frame: start, 8 data bits LSB first, stop.
- FIFO_DEPTH, 4, entries in the output queue; power of two, at least 2.
- clk  input  1  system clock, same clock as the receive controller.
- rst  input  1  synchronous, active-high reset.
- ser_data_in  input  1  raw serial line, asynchronous.
- sr_clk  input  1  shift strobe from the controller; level held for many clk cycles; one sample per rising edge.
- char_received  input  1  end-of-character flag from the controller; level; one frame close per rising edge.
- rx_data  output  8  data byte at FIFO head; 0 when empty.
- rx_err  output  1  framing-error flag at FIFO head; 0 when empty.
- rx_valid  output  1  FIFO non-empty.
- rx_ready  input  1  consumer accepts head entry when rx_valid && rx_ready.
- rx_count  output  $clog2(FIFO_DEPTH)+1  number of queued entries.
- overflow  output  1  sticky: a frame was dropped because the FIFO was full.
- overflow_clr  input  1  clears overflow.

## Operation
- Reset state: all outputs 0, shift register 0, bit_cnt 0, FIFO empty, edge-detect history 0, sync flops 1 (idle line).
- ser_data_in passes through a 2-flop synchronizer; ser_s is the second stage.
- Edge detect: sr_rise = sr_clk && !sr_clk_q; cr_rise = char_received && !char_received_q; the _q registers update every cycle.
- On sr_rise with bit_cnt < FRAME_BITS: shift_reg[bit_cnt] <= ser_s; bit_cnt += 1. On sr_rise with bit_cnt == FRAME_BITS: sample discarded, long flag set.
- On cr_rise, the frame closes:
  - data = shift_reg[8:1].
  - err = (bit_cnt != FRAME_BITS) || long || shift_reg[0] != 0 || shift_reg[FRAME_BITS-1] != 1.
  - Push {err, data}. If the FIFO is full and no pop occurs in the same cycle, drop the entry and set overflow.
  - Clear bit_cnt, long, shift_reg.
- When sr_rise and cr_rise coincide, the sample is included in the closing frame, then state clears.
- FIFO: circular buffer with read/write pointers one bit wider than the index, so full and empty are distinguished on wrap.
  - A push and a pop in the same cycle are both accepted whether the FIFO is full or not; rx_count is unchanged and overflow is not set.
- overflow_clr clears overflow. If a drop occurs in the same cycle, set wins.

## Timing
- sr_rise in cycle S: sample visible in shift_reg at cycle S+1.
- ser_data_in changes: visible at ser_s 2 cycles later.
- cr_rise in cycle E with the FIFO empty: rx_valid=1 and rx_data/rx_err valid in cycle E+1. There is no fall-through within cycle E.
- Pop in cycle P: the next head entry, or rx_valid=0, appears in cycle P+1. rx_count updates in P+1.
- rx_data, rx_err and rx_valid are held stable while rx_valid && !rx_ready.
- rst asserted mid-frame or with the FIFO non-empty: every register returns to its reset value at the next edge. Queued data is lost, and no partial frame is pushed after reset.

## Structure
- Package serial_rx_pkg holds:
  - DATA_BITS=8 and the default FRAME_BITS.
  - Typedef rx_entry_t {logic err; logic [7:0] data}.
- Sub-module rx_fifo: parameterized on depth and rx_entry_t, with push/pop/full/empty/count. It is also reused by the transmit path.
- The frame assembler, synchronizer and edge detect stay in the top level.

## Test plan
- Frame 0x55: send 10 sr_clk rises with line bits 0,1,0,1,0,1,0,1,0,1, then char_received rise. Expect rx_valid at E+1 with rx_data=0x55, rx_err=0, rx_count=1.
- Bad stop bit: frame 0xA3 with stop sampled 0. Expect rx_data=0xA3, rx_err=1.
- Short frame: 9 samples, then close. Expect rx_err=1. Long frame: 11 samples. Expect rx_err=1, and data taken from the first 10 samples.
- Overflow: push 5 good frames with rx_ready=0 at depth 4. Expect rx_count=4, overflow=1, and pops return frames 1–4 in order. Then pulse overflow_clr: expect overflow=0.
- Full boundary: with the FIFO full, a cr_rise and a pop in the same cycle. Expect count stays 4, overflow stays 0, and the new entry appears last.
- Reset mid-frame: assert rst after 5 samples with 2 entries queued. Expect rx_valid=0 and rx_count=0 at the next cycle. A following clean 0x3C frame decodes correctly.
